// File: rtl/apb_arb_pkg.sv
// Shared types for the two-requester APB arbiter.
package apb_arb_pkg;

    localparam int NUM_REQ = 2;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } apb_state_t;

    typedef logic [0:0] req_idx_t;

endpackage

// File: rtl/apb_req_arbiter_rr_arb2.sv
// Two-way round-robin pick: a lone eligible requester wins outright; when
// both are eligible, the one that did not win last time is chosen.
module rr_arb2
    import apb_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] eligible,
    input  logic               last_gnt,
    output logic               gnt_valid,
    output logic               gnt_idx
);

    assign gnt_valid = |eligible;

    // Winner index: requester 1 when it alone is eligible, otherwise rotate on ties
    always_comb begin
        gnt_idx = eligible[1];
        if (&eligible) begin
            gnt_idx = ~last_gnt;
        end
    end

endmodule

// File: rtl/apb_req_arbiter.sv
// Shares one APB master port between two requesters with round-robin
// arbitration, sequencing SETUP/ACCESS and returning done/err/rdata.
// Optional feature macro: APB_TIMEOUT_EN (abort ACCESS after TIMEOUT_CYCLES).
module apb_req_arbiter
    import apb_arb_pkg::*;
#(
    parameter  int ADDR_W         = 8,
    parameter  int DATA_W         = 8,
    parameter  int NUM_DEV        = 4,
    parameter  int TIMEOUT_CYCLES = 16,
    localparam int DEV_W          = $clog2(NUM_DEV) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req,
    input  logic [1:0]            wr,
    input  logic [2*ADDR_W-1:0]   addr,
    input  logic [2*DATA_W-1:0]   wdata,
    input  logic [2*DEV_W-1:0]    dev,
    output logic [1:0]            done,
    output logic                  err,
    output logic [DATA_W-1:0]     rdata,
    output logic [NUM_DEV-1:0]    psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_W-1:0]     paddr,
    output logic [DATA_W-1:0]     pwdata,
    input  logic [DATA_W-1:0]     prdata,
    input  logic                  pready
);

    apb_state_t        state_q, state_d;
    req_idx_t          owner_q, owner_d;
    logic              last_gnt_q, last_gnt_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DEV_W-1:0]  dev_q, dev_d;
    logic [1:0]        done_q, done_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

`ifdef APB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0]  tmo_q, tmo_d;
`endif

    // A requester whose done is pulsing this cycle sits out the arbitration.
    logic [1:0]        eligible;
    logic              gnt_valid;
    logic              gnt_idx;
    logic              sel_wr;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [DEV_W-1:0]  sel_dev;

    assign eligible  = req & ~done_q;
    assign sel_wr    = gnt_idx ? wr[1] : wr[0];
    assign sel_addr  = gnt_idx ? addr[2*ADDR_W-1:ADDR_W]   : addr[ADDR_W-1:0];
    assign sel_wdata = gnt_idx ? wdata[2*DATA_W-1:DATA_W]  : wdata[DATA_W-1:0];
    assign sel_dev   = gnt_idx ? dev[2*DEV_W-1:DEV_W]      : dev[DEV_W-1:0];

    rr_arb2 u_rr_arb2 (
        .eligible  (eligible),
        .last_gnt  (last_gnt_q),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    // Next-state: arbitrate in IDLE, walk SETUP -> ACCESS, register completion
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_gnt_d = last_gnt_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        dev_d      = dev_q;
        done_d     = 2'b00;
        err_d      = 1'b0;
        rdata_d    = rdata_q;
`ifdef APB_TIMEOUT_EN
        tmo_d      = tmo_q;
`endif
        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    owner_d = gnt_idx;
                    if (sel_dev >= DEV_W'(NUM_DEV)) begin
                        // No such slave: fail immediately, bus pins untouched
                        done_d[gnt_idx] = 1'b1;
                        err_d           = 1'b1;
                        last_gnt_d      = gnt_idx;
                    end else begin
                        wr_d    = sel_wr;
                        addr_d  = sel_addr;
                        wdata_d = sel_wdata;
                        dev_d   = sel_dev;
                        state_d = SETUP;
                    end
                end
            end
            SETUP: begin
`ifdef APB_TIMEOUT_EN
                tmo_d   = '0;
`endif
                state_d = ACCESS;
            end
            ACCESS: begin
                if (pready) begin
                    if (!wr_q) begin
                        rdata_d = prdata;
                    end
                    done_d[owner_q] = 1'b1;
                    last_gnt_d      = owner_q;
                    state_d         = IDLE;
`ifdef APB_TIMEOUT_EN
                end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    done_d[owner_q] = 1'b1;
                    err_d           = 1'b1;
                    last_gnt_d      = owner_q;
                    state_d         = IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and transfer registers; reset returns the bus to a quiet IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            last_gnt_q <= 1'b1;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            dev_q      <= '0;
            done_q     <= 2'b00;
            err_q      <= 1'b0;
            rdata_q    <= '0;
`ifdef APB_TIMEOUT_EN
            tmo_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_gnt_q <= last_gnt_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            dev_q      <= dev_d;
            done_q     <= done_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
`ifdef APB_TIMEOUT_EN
            tmo_q      <= tmo_d;
`endif
        end
    end

    // One-hot slave select for the latched device while a transfer is on the bus
    always_comb begin
        psel = '0;
        for (int i = 0; i < NUM_DEV; i++) begin
            psel[i] = (state_q != IDLE) && (dev_q == DEV_W'(i));
        end
    end

    assign penable = (state_q == ACCESS);
    assign pwrite  = wr_q;
    assign paddr   = addr_q;
    assign pwdata  = wdata_q;
    assign done    = done_q;
    assign err     = err_q;
    assign rdata   = rdata_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Self-checking bench for apb_req_arbiter: directed scenarios plus a
// randomized run, compared every cycle against a transaction-age model.
module tb_apb_req_arbiter;

    localparam int ADDR_W         = 8;
    localparam int DATA_W         = 8;
    localparam int NUM_DEV        = 4;
    localparam int TIMEOUT_CYCLES = 16;
    localparam int DEV_W          = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req, wr;
    logic [15:0] addr, wdata;
    logic [5:0]  dev;
    logic [1:0]  done;
    logic        err;
    logic [7:0]  rdata;
    logic [3:0]  psel;
    logic        penable, pwrite;
    logic [7:0]  paddr, pwdata, prdata;
    logic        pready;

    always #5 clk = ~clk;

    apb_req_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_DEV(NUM_DEV), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .wr(wr), .addr(addr), .wdata(wdata), .dev(dev),
        .done(done), .err(err), .rdata(rdata), .psel(psel), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Requester-side fields
    logic       r_wr[2];
    logic [7:0] r_addr[2], r_wd[2];
    logic [2:0] r_dev[2];

    task automatic pack_inputs();
        wr    = {r_wr[1], r_wr[0]};
        addr  = {r_addr[1], r_addr[0]};
        wdata = {r_wd[1], r_wd[0]};
        dev   = {r_dev[1], r_dev[0]};
    endtask

    task automatic set_req(input int i, input logic w, input logic [7:0] a,
                           input logic [7:0] d, input logic [2:0] dv);
        r_wr[i] = w; r_addr[i] = a; r_wd[i] = d; r_dev[i] = dv;
        req[i]  = 1'b1;
        pack_inputs();
    endtask

    // Reference model: a transfer is tracked by its age since grant
    // (age 1 = address phase, age >= 2 = enable phase).
    bit         m_active;
    int         m_owner;
    int         m_age;
    int         m_last;
    logic [1:0] m_done;
    logic       m_err;
    logic [7:0] m_rdata, m_addr, m_wd;
    logic       m_wr;
    logic [2:0] m_dev;

    task automatic model_reset();
        m_active = 0; m_owner = 0; m_age = 0; m_last = 1;
        m_done = 2'b00; m_err = 1'b0; m_rdata = 8'h00;
        m_wr = 1'b0; m_addr = 8'h00; m_wd = 8'h00; m_dev = 3'd0;
    endtask

    task automatic model_step();
        logic [1:0] elig, nd;
        logic       ne;
        int         w;
        if (rst) begin
            model_reset();
            return;
        end
        nd = 2'b00;
        ne = 1'b0;
        if (!m_active) begin
            elig = req & ~m_done;
            if (elig != 2'b00) begin
                w = (elig == 2'b11) ? 1 - m_last : (elig[1] ? 1 : 0);
                if (r_dev[w] >= NUM_DEV) begin
                    nd[w] = 1'b1; ne = 1'b1; m_last = w;
                end else begin
                    m_active = 1; m_owner = w; m_age = 1;
                    m_wr = r_wr[w]; m_addr = r_addr[w]; m_wd = r_wd[w]; m_dev = r_dev[w];
                end
            end
        end else if (m_age == 1) begin
            m_age = 2;
        end else if (pready) begin
            if (!m_wr) m_rdata = prdata;
            nd[m_owner] = 1'b1; m_last = m_owner; m_active = 0;
        end else begin
            m_age++;
`ifdef APB_TIMEOUT_EN
            if (m_age - 2 >= TIMEOUT_CYCLES) begin
                nd[m_owner] = 1'b1; ne = 1'b1; m_last = m_owner; m_active = 0;
            end
`endif
        end
        m_done = nd;
        m_err  = ne;
    endtask

    task automatic compare_outputs();
        logic [3:0] e_psel;
        e_psel = m_active ? (4'b0001 << m_dev) : 4'b0000;
        check_eq("psel",    32'(psel),    32'(e_psel));
        check_eq("penable", 32'(penable), 32'(m_active && m_age >= 2));
        check_eq("pwrite",  32'(pwrite),  32'(m_wr));
        check_eq("paddr",   32'(paddr),   32'(m_addr));
        check_eq("pwdata",  32'(pwdata),  32'(m_wd));
        check_eq("done",    32'(done),    32'(m_done));
        check_eq("err",     32'(err),     32'(m_err));
        check_eq("rdata",   32'(rdata),   32'(m_rdata));
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        compare_outputs();
    endtask

    task automatic do_reset();
        rst = 1'b1; req = 2'b00; pready = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            r_wr[i] = 1'b0; r_addr[i] = 8'h00; r_wd[i] = 8'h00; r_dev[i] = 3'd0;
        end
        pack_inputs();
        req = 2'b00; prdata = 8'h00; pready = 1'b1; rst = 1'b1;
        model_reset();

        // Reset state
        do_reset();
        check_eq("rst_psel",    32'(psel),    32'h0);
        check_eq("rst_penable", 32'(penable), 32'h0);
        check_eq("rst_done",    32'(done),    32'h0);
        check_eq("rst_rdata",   32'(rdata),   32'h0);

        // Single read through dev 1
        prdata = 8'hA5;
        set_req(0, 1'b0, 8'h10, 8'h00, 3'd1);
        step();
        check_eq("rd_setup_psel", 32'(psel), 32'h2);
        check_eq("rd_setup_pen",  32'(penable), 32'h0);
        step();
        check_eq("rd_access_pen", 32'(penable), 32'h1);
        check_eq("rd_paddr",      32'(paddr), 32'h10);
        step();
        check_eq("rd_done",  32'(done),  32'h1);
        check_eq("rd_rdata", 32'(rdata), 32'hA5);
        check_eq("rd_err",   32'(err),   32'h0);
        req = 2'b00;
        step();

        // Contention from reset, both held: 0,1,0,1 every 3 cycles
        do_reset();
        set_req(0, 1'b1, 8'h20, 8'h11, 3'd0);
        set_req(1, 1'b1, 8'h30, 8'h22, 3'd3);
        for (int s = 1; s <= 12; s++) begin
            step();
            if (s % 3 == 0)
                check_eq("contend_done", 32'(done), ((s / 3) % 2 == 1) ? 32'h1 : 32'h2);
        end
        req = 2'b00;
        step();

        // Write with four wait-state ACCESS cycles
        do_reset();
        pready = 1'b0;
        set_req(1, 1'b1, 8'h44, 8'h3C, 3'd2);
        step();
        for (int k = 0; k < 4; k++) begin
            step();
            check_eq("ws_psel",   32'(psel),    32'h4);
            check_eq("ws_pen",    32'(penable), 32'h1);
            check_eq("ws_pwdata", 32'(pwdata),  32'h3C);
            check_eq("ws_done",   32'(done),    32'h0);
        end
        pready = 1'b1;
        step();
        check_eq("ws_done_after", 32'(done), 32'h2);
        req = 2'b00;
        step();

        // Out-of-range device
        do_reset();
        set_req(0, 1'b0, 8'h55, 8'h00, 3'd4);
        step();
        check_eq("oor_psel", 32'(psel), 32'h0);
        check_eq("oor_done", 32'(done), 32'h1);
        check_eq("oor_err",  32'(err),  32'h1);
        req = 2'b00;
        step();

        // Reset during ACCESS, then fresh service
        do_reset();
        pready = 1'b0;
        set_req(0, 1'b0, 8'h66, 8'h00, 3'd2);
        step(); step(); step();
        rst = 1'b1;
        step();
        check_eq("rsta_psel", 32'(psel),    32'h0);
        check_eq("rsta_pen",  32'(penable), 32'h0);
        check_eq("rsta_done", 32'(done),    32'h0);
        rst = 1'b0; pready = 1'b1; prdata = 8'h5A;
        step(); step(); step();
        check_eq("rsta_redo_done",  32'(done),  32'h1);
        check_eq("rsta_redo_rdata", 32'(rdata), 32'h5A);
        req = 2'b00;
        step();

        // Slave never ready
        do_reset();
        pready = 1'b0;
        set_req(0, 1'b0, 8'h77, 8'h00, 3'd3);
        step(); step();
`ifdef APB_TIMEOUT_EN
        for (int k = 0; k < TIMEOUT_CYCLES; k++) step();
        check_eq("tmo_done", 32'(done), 32'h1);
        check_eq("tmo_err",  32'(err),  32'h1);
`else
        for (int k = 0; k < 20; k++) step();
        check_eq("hang_pen", 32'(penable), 32'h1);
        pready = 1'b1;
        step();
        check_eq("hang_done", 32'(done), 32'h1);
`endif
        req = 2'b00; pready = 1'b1;
        step();

        // Randomized traffic with occasional bad devices, wait states and resets
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 2; i++) begin
                if ((req[i] && done[i]) || (!req[i] && ($urandom % 4 == 0))) begin
                    req[i]    = ($urandom % 3 != 0);
                    r_wr[i]   = 1'($urandom % 2);
                    r_addr[i] = 8'($urandom);
                    r_wd[i]   = 8'($urandom);
                    r_dev[i]  = ($urandom % 8 == 0) ? 3'(4 + $urandom % 4) : 3'($urandom % 4);
                end
            end
            pack_inputs();
            pready = ($urandom % 3 != 0);
            prdata = 8'($urandom);
            rst    = ($urandom % 200 == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
